// File: rtl/spi_link_tx_8lane.sv
// Eight-lane SPI-style transmitter: queues 128-bit blocks in a small FIFO and
// sends each one MSB-first as sixteen bytes framed by an active-low select.
module spi_link_tx_8lane #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4,
    parameter int DEPTH      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [127:0]           in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   spi_clk,
    output logic [7:0]             spi_data,
    output logic                   spi_cs_n,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   frame_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LO, HI, GAP} state_t;

    state_t            state;
    logic [127:0]      mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [119:0]      shreg;
    logic [3:0]        byte_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              push;
    logic              pop;
    logic              div_last;
    logic              advance;

    assign in_ready = (fifo_count != FULL_CNT) && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && (fifo_count != '0);
    assign div_last = (div_cnt == DIV_LAST);
    assign advance  = (state == HI) && div_last && (byte_cnt != 4'd15);
    assign busy     = (state != IDLE) || (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Byte 0 goes straight from the FIFO to spi_data; the shifter holds bytes 1..15.
    always_ff @(posedge clk) begin
        if (pop) begin
            shreg <= mem[rd_ptr][119:0];
        end else if (advance) begin
            shreg <= {shreg[111:0], 8'h00};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            spi_cs_n   <= 1'b1;
            spi_clk    <= 1'b0;
            spi_data   <= 8'h00;
            frame_done <= 1'b0;
            byte_cnt   <= '0;
            div_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        spi_cs_n <= 1'b0;
                        spi_clk  <= 1'b0;
                        spi_data <= mem[rd_ptr][127:120];
                        byte_cnt <= '0;
                        div_cnt  <= '0;
                        state    <= LO;
                    end
                end
                LO: begin
                    if (div_last) begin
                        spi_clk <= 1'b1;
                        div_cnt <= '0;
                        state   <= HI;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                HI: begin
                    if (div_last) begin
                        spi_clk <= 1'b0;
                        div_cnt <= '0;
                        if (byte_cnt == 4'd15) begin
                            spi_cs_n   <= 1'b1;
                            spi_data   <= 8'h00;
                            frame_done <= 1'b1;
                            gap_cnt    <= '0;
                            state      <= GAP;
                        end else begin
                            spi_data <= shreg[119:112];
                            byte_cnt <= byte_cnt + 4'd1;
                            state    <= LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_link_tx_8lane.sv
// Bench for spi_link_tx_8lane: two instances (CLK_DIV=2 and CLK_DIV=1) driven with
// directed and random blocks; a negedge monitor checks frames against a block queue.
module tb_spi_link_tx_8lane;

    localparam int DIV0 = 2, GAP0 = 4, DEP0 = 2;
    localparam int DIV1 = 1, GAP1 = 2, DEP1 = 4;

    logic         clk;
    logic         rst_v      [2];
    logic         in_valid_v [2];
    logic [127:0] in_data_v  [2];
    logic         in_ready_v [2];
    logic         spi_clk_v  [2];
    logic [7:0]   sdata_v    [2];
    logic         cs_v       [2];
    logic         busy_v     [2];
    logic         done_v     [2];
    logic [1:0]   fcnt0;
    logic [2:0]   fcnt1;
    int           fcnt_v     [2];

    assign fcnt_v[0] = int'(fcnt0);
    assign fcnt_v[1] = int'(fcnt1);

    spi_link_tx_8lane #(.CLK_DIV(DIV0), .GAP_CYCLES(GAP0), .DEPTH(DEP0)) dut0 (
        .clk(clk), .rst(rst_v[0]), .in_data(in_data_v[0]), .in_valid(in_valid_v[0]),
        .in_ready(in_ready_v[0]), .spi_clk(spi_clk_v[0]), .spi_data(sdata_v[0]),
        .spi_cs_n(cs_v[0]), .busy(busy_v[0]), .fifo_count(fcnt0), .frame_done(done_v[0])
    );

    spi_link_tx_8lane #(.CLK_DIV(DIV1), .GAP_CYCLES(GAP1), .DEPTH(DEP1)) dut1 (
        .clk(clk), .rst(rst_v[1]), .in_data(in_data_v[1]), .in_valid(in_valid_v[1]),
        .in_ready(in_ready_v[1]), .spi_clk(spi_clk_v[1]), .spi_data(sdata_v[1]),
        .spi_cs_n(cs_v[1]), .busy(busy_v[1]), .fifo_count(fcnt1), .frame_done(done_v[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_true(input string name, input bit ok, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? DIV0 : DIV1;
    endfunction
    function automatic int gap_of(input int i);
        return (i == 0) ? GAP0 : GAP1;
    endfunction
    function automatic int dep_of(input int i);
        return (i == 0) ? DEP0 : DEP1;
    endfunction

    // Byte k of a block, most significant byte first.
    function automatic logic [7:0] byte_of(input logic [127:0] b, input int k);
        logic [127:0] s;
        s = b >> (120 - 8 * k);
        return s[7:0];
    endfunction

    // Scoreboard: accepted blocks not yet started, plus per-frame progress.
    logic [127:0] exp_q [2][$];
    logic [127:0] cur_blk      [2];
    bit           prev_clk     [2];
    bit           prev_cs      [2];
    bit           in_frame     [2];
    bit           seen_frame   [2];
    bit           pend_at_done [2];
    int           low_cnt      [2];
    int           high_cnt     [2];
    int           byte_idx     [2];
    int           started      [2];
    int           finished     [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            prev_clk[i] = 1'b0; prev_cs[i] = 1'b1; in_frame[i] = 1'b0;
            seen_frame[i] = 1'b0; pend_at_done[i] = 1'b0; low_cnt[i] = 0;
            high_cnt[i] = 0; byte_idx[i] = 0; started[i] = 0; finished[i] = 0;
            cur_blk[i] = '0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_v[i]) begin
                exp_q[i].delete();
                if (in_frame[i]) started[i]--;
                in_frame[i]   = 1'b0;
                seen_frame[i] = 1'b0;
                prev_cs[i]    = 1'b1;
                prev_clk[i]   = 1'b0;
                byte_idx[i]   = 0;
                high_cnt[i]   = 0;
            end else begin
                if (prev_cs[i] && !cs_v[i]) begin
                    if (seen_frame[i]) begin
                        chk_true("gap_min", high_cnt[i] >= gap_of(i) + 1, high_cnt[i], gap_of(i) + 1);
                        if (pend_at_done[i])
                            chk_eq("gap_exact", high_cnt[i], gap_of(i) + 1);
                    end
                    if (exp_q[i].size() == 0) begin
                        chk_eq("frame_without_block", 1, 0);
                    end else begin
                        cur_blk[i] = exp_q[i].pop_front();
                    end
                    in_frame[i] = 1'b1;
                    low_cnt[i]  = 0;
                    byte_idx[i] = 0;
                    started[i]++;
                end
                if (!cs_v[i]) begin
                    low_cnt[i]++;
                    chk_eq("busy_in_frame", int'(busy_v[i]), 1);
                end else begin
                    high_cnt[i]++;
                    chk_eq("idle_lines", int'({spi_clk_v[i], sdata_v[i]}), 0);
                end
                if (!prev_clk[i] && spi_clk_v[i]) begin
                    if (!in_frame[i] || cs_v[i]) begin
                        chk_eq("clk_outside_frame", 1, 0);
                    end else begin
                        if (byte_idx[i] < 16)
                            chk_eq($sformatf("byte%0d_dut%0d", byte_idx[i], i),
                                   int'(sdata_v[i]), int'(byte_of(cur_blk[i], byte_idx[i])));
                        byte_idx[i]++;
                    end
                end
                if (!prev_cs[i] && cs_v[i]) begin
                    chk_eq("frame_len", low_cnt[i], 32 * div_of(i));
                    chk_eq("rise_edges", byte_idx[i], 16);
                    chk_eq("frame_done_at_end", int'(done_v[i]), 1);
                    finished[i]++;
                    in_frame[i]     = 1'b0;
                    seen_frame[i]   = 1'b1;
                    pend_at_done[i] = (exp_q[i].size() > 0);
                    high_cnt[i]     = 1;
                end else if (done_v[i]) begin
                    chk_eq("stray_frame_done", int'(done_v[i]), 0);
                end
                chk_eq("fifo_count", fcnt_v[i], exp_q[i].size());
                chk_eq("in_ready", int'(in_ready_v[i]), int'(exp_q[i].size() != dep_of(i)));
                if (in_valid_v[i] && in_ready_v[i])
                    exp_q[i].push_back(in_data_v[i]);
                prev_cs[i]  = cs_v[i];
                prev_clk[i] = spi_clk_v[i];
            end
        end
    end

    // Callers are aligned 1 time unit after a rising edge; returns the same way.
    task automatic send(input int i, input logic [127:0] blk, input int budget);
        bit ok;
        ok = 1'b0;
        in_data_v[i]  = blk;
        in_valid_v[i] = 1'b1;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (in_ready_v[i]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid_v[i] = 1'b0;
        if (!ok) chk_eq("send_timeout", 0, 1);
    endtask

    task automatic wait_done(input int i, input int budget);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (done_v[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk_eq("frame_done_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input int i, input string tag);
        chk_eq({tag, "_cs_n"}, int'(cs_v[i]), 1);
        chk_eq({tag, "_spi_clk"}, int'(spi_clk_v[i]), 0);
        chk_eq({tag, "_spi_data"}, int'(sdata_v[i]), 0);
        chk_eq({tag, "_frame_done"}, int'(done_v[i]), 0);
        chk_eq({tag, "_busy"}, int'(busy_v[i]), 0);
        chk_eq({tag, "_in_ready"}, int'(in_ready_v[i]), 0);
        chk_eq({tag, "_fifo_count"}, fcnt_v[i], 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] blk;
        int           n_before;
        bit           ok;

        for (int i = 0; i < 2; i++) begin
            rst_v[i] = 1'b1; in_valid_v[i] = 1'b0; in_data_v[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs(0, "reset0");
        chk_idle_outputs(1, "reset1");
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
        #1;
        chk_eq("ready_after_reset", int'(in_ready_v[0]), 1);
        @(posedge clk);
        #1;

        // Known block on the CLK_DIV=2 instance, with first-transaction latency.
        in_data_v[0]  = 128'h00112233445566778899AABBCCDDEEFF;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[0] = 1'b0;
        chk_eq("lat_e0_cs_n", int'(cs_v[0]), 1);
        chk_eq("lat_e0_count", fcnt_v[0], 1);
        @(posedge clk);
        #1;
        chk_eq("lat_e1_cs_n", int'(cs_v[0]), 0);
        chk_eq("lat_e1_data", int'(sdata_v[0]), 8'h00);
        wait_done(0, 200);
        chk_eq("single_frame_count", finished[0], 1);

        // All-ones block on the CLK_DIV=1 instance: spi_clk toggles every cycle.
        in_data_v[1]  = {128{1'b1}};
        in_valid_v[1] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[1] = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(posedge clk);
            #1;
            chk_eq("div1_toggle", int'(spi_clk_v[1]), t % 2);
        end
        wait_done(1, 100);

        // Three blocks offered back-to-back into a two-entry FIFO.
        send(0, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF, 20);
        send(0, 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF, 20);
        send(0, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF, 20);
        chk_eq("full_in_ready", int'(in_ready_v[0]), 0);
        chk_eq("full_count", fcnt_v[0], 2);
        for (int k = 0; k < 3; k++) wait_done(0, 400);

        // Push while the FSM is in GAP with one block waiting.
        send(0, 128'h0102030405060708090A0B0C0D0E0F10, 20);
        send(0, 128'h1112131415161718191A1B1C1D1E1F20, 20);
        wait_done(0, 400);
        chk_eq("gap_count_before", fcnt_v[0], 1);
        send(0, 128'h2122232425262728292A2B2C2D2E2F30, 20);
        chk_eq("gap_count_after", fcnt_v[0], 2);
        for (int k = 0; k < 2; k++) wait_done(0, 400);

        // Reset in the middle of byte 5 with a second block queued.
        send(0, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 20);
        send(0, 128'h55AA55AA_55AA55AA_55AA55AA_55AA55AA, 20);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (byte_idx[0] >= 6) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk_eq("reach_byte5_timeout", 0, 1);
        @(posedge clk);
        #1;
        n_before = finished[0];
        rst_v[0] = 1'b1;
        #1;
        chk_idle_outputs(0, "midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_v[0] = 1'b0;
        chk_eq("no_done_on_abort", finished[0], n_before);
        send(0, 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, 20);
        wait_done(0, 200);

        // Random blocks with random idle spacing on both instances at once.
        fork
            for (int n = 0; n < 20; n++) begin
                blk = {$urandom(), $urandom(), $urandom(), $urandom()};
                repeat ($urandom_range(0, 40)) begin @(posedge clk); #1; end
                send(0, blk, 400);
            end
            begin
                logic [127:0] b1;
                for (int n = 0; n < 30; n++) begin
                    b1 = {$urandom(), $urandom(), $urandom(), $urandom()};
                    repeat ($urandom_range(0, 20)) begin @(posedge clk); #1; end
                    send(1, b1, 400);
                end
            end
        join

        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && !busy_v[0] && !busy_v[1]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk_eq("drain_timeout", 0, 1);
        for (int i = 0; i < 2; i++) begin
            chk_eq("final_cs_n", int'(cs_v[i]), 1);
            chk_eq("final_count", fcnt_v[i], 0);
            chk_eq("frames_completed", finished[i], started[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
